// File: rtl/iq_capture_pkg.sv
// Shared types and helpers for the IQ frame capture block.
// Used by axis_iq_frame_capture; the optional energy path is enabled with IQ_CAPTURE_ENERGY_EN.
package iq_capture_pkg;

  localparam int SAMP_W         = 16;
  localparam int SAMPS_PER_BEAT = 4;
  localparam int BEAT_W         = 2 * SAMP_W * SAMPS_PER_BEAT;

  typedef struct packed {
    logic signed [SAMP_W-1:0] q;
    logic signed [SAMP_W-1:0] i;
  } iq_samp_t;

  // Sample 0 sits in the low bits: {Q3,I3,...,Q0,I0}.
  typedef iq_samp_t [SAMPS_PER_BEAT-1:0] iq_beat_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  function automatic iq_beat_t unpack_beat(input logic [BEAT_W-1:0] d);
    iq_beat_t b;
    b = d;
    return b;
  endfunction

  function automatic logic [2*SAMP_W-1:0] iq_sq(input logic signed [SAMP_W-1:0] x);
    logic signed [2*SAMP_W-1:0] p;
    p = x * x;
    return p;
  endfunction

endpackage

// File: rtl/iq_capture_ram.sv
// Simple dual-port frame buffer with a registered read port.
// A same-cycle read of the address being written returns the old word.
module iq_capture_ram #(
  parameter int DEPTH  = 320,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array: no reset so a partial frame survives for inspection.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axis_iq_frame_capture.sv
// AXI-Stream sink that aligns on tlast and captures one fixed-length IQ frame into RAM.
// Optional frame energy accumulator is enabled by defining IQ_CAPTURE_ENERGY_EN.
module axis_iq_frame_capture #(
  parameter int SAMP_W         = iq_capture_pkg::SAMP_W,
  parameter int SAMPS_PER_BEAT = iq_capture_pkg::SAMPS_PER_BEAT,
  parameter int FRAME_BEATS    = 320,
  parameter int ADDR_W         = 9
) (
  input  logic                                 s_axis_aclk,
  input  logic                                 s_axis_areset,
  input  logic [2*SAMP_W*SAMPS_PER_BEAT-1:0]   s_axis_tdata,
  input  logic [7:0]                           s_axis_tid,
  input  logic                                 s_axis_tlast,
  input  logic [7:0]                           s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 arm,
  input  logic [7:0]                           cfg_tid,
  input  logic [ADDR_W-1:0]                    rd_addr,
  output logic [2*SAMP_W*SAMPS_PER_BEAT-1:0]   rd_data,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 err_short,
  output logic                                 err_long,
  output logic [ADDR_W:0]                      beat_count
`ifdef IQ_CAPTURE_ENERGY_EN
  ,
  output logic [47:0]                          frame_energy
`endif
);

  import iq_capture_pkg::*;

  localparam int              DATA_W = 2 * SAMP_W * SAMPS_PER_BEAT;
  localparam logic [ADDR_W:0] FULL   = (ADDR_W+1)'(FRAME_BEATS);
  localparam logic [ADDR_W:0] LAST   = (ADDR_W+1)'(FRAME_BEATS - 1);

  cap_state_e      state, state_nx;
  logic            aligned, aligned_nx, hit, we;
  logic            done_q, short_q, long_q;
  logic            done_nx, short_nx, long_nx;
  logic [ADDR_W:0] count_nx;
  logic            unused_tuser;

  assign unused_tuser = ^s_axis_tuser;
  assign hit          = s_axis_tvalid && s_axis_tready && (s_axis_tid == cfg_tid);
  // The arm decision sees the tlast of a hit arriving in the same cycle.
  assign aligned_nx   = hit ? s_axis_tlast : aligned;

  // Next-state, RAM write and flag/count update logic.
  always_comb begin
    state_nx = state;
    done_nx  = done_q;
    short_nx = short_q;
    long_nx  = long_q;
    count_nx = beat_count;
    we       = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nx = aligned_nx ? CAPTURE : SYNC;
        else     state_nx = IDLE;
      end
      SYNC: begin
        if (arm)                        state_nx = aligned_nx ? CAPTURE : SYNC;
        else if (hit && s_axis_tlast)   state_nx = CAPTURE;
        else                            state_nx = SYNC;
      end
      CAPTURE: begin
        if (hit && (beat_count != FULL)) begin
          we       = 1'b1;
          count_nx = beat_count + (ADDR_W+1)'(1);
          if (!s_axis_tlast && (beat_count == LAST)) long_nx = 1'b1;
          else                                       long_nx = long_q;
        end else begin
          we = 1'b0;
        end
        if (hit && s_axis_tlast) begin
          done_nx  = 1'b1;
          short_nx = (beat_count < LAST);
        end else begin
          done_nx  = done_q;
        end
        if (arm)                      state_nx = SYNC;
        else if (hit && s_axis_tlast) state_nx = DONE;
        else                          state_nx = CAPTURE;
      end
      DONE: begin
        if (arm) state_nx = aligned_nx ? CAPTURE : SYNC;
        else     state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, alignment, flags and beat counter; arm clears the capture results.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state         <= IDLE;
      aligned       <= 1'b0;
      busy          <= 1'b0;
      s_axis_tready <= 1'b0;
      done_q        <= 1'b0;
      short_q       <= 1'b0;
      long_q        <= 1'b0;
      beat_count    <= '0;
    end else begin
      state         <= state_nx;
      aligned       <= aligned_nx;
      busy          <= (state_nx == SYNC) || (state_nx == CAPTURE);
      s_axis_tready <= 1'b1;
      if (arm) begin
        done_q     <= 1'b0;
        short_q    <= 1'b0;
        long_q     <= 1'b0;
        beat_count <= '0;
      end else begin
        done_q     <= done_nx;
        short_q    <= short_nx;
        long_q     <= long_nx;
        beat_count <= count_nx;
      end
    end
  end

  iq_capture_ram #(
    .DEPTH  (FRAME_BEATS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (s_axis_aclk),
    .rst     (s_axis_areset),
    .we      (we),
    .wr_addr (beat_count[ADDR_W-1:0]),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef IQ_CAPTURE_ENERGY_EN
  localparam int SQ_W = 2 * SAMP_W + $clog2(2 * SAMPS_PER_BEAT);

  iq_beat_t        beat;
  logic [SQ_W-1:0] sq_sum, sq_sum_q;
  logic            sq_vld, done_d, short_d, long_d;

  assign beat = unpack_beat(s_axis_tdata);

  // Per-beat sum of squares; squares are non-negative so they add unsigned.
  always_comb begin
    sq_sum = '0;
    for (int k = 0; k < SAMPS_PER_BEAT; k++) begin
      sq_sum = sq_sum + SQ_W'(iq_sq(beat[k].i)) + SQ_W'(iq_sq(beat[k].q));
    end
  end

  // Two-stage energy pipeline; flags are delayed to line up with the final energy.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      sq_vld       <= 1'b0;
      sq_sum_q     <= '0;
      frame_energy <= '0;
      done_d       <= 1'b0;
      short_d      <= 1'b0;
      long_d       <= 1'b0;
    end else begin
      sq_vld   <= we && !arm;
      sq_sum_q <= sq_sum;
      if (arm) begin
        frame_energy <= '0;
        done_d       <= 1'b0;
        short_d      <= 1'b0;
        long_d       <= 1'b0;
      end else begin
        if (sq_vld) frame_energy <= frame_energy + 48'(sq_sum_q);
        else        frame_energy <= frame_energy;
        done_d  <= done_q;
        short_d <= short_q;
        long_d  <= long_q;
      end
    end
  end

  assign frame_done = done_d;
  assign err_short  = short_d;
  assign err_long   = long_d;
`else
  assign frame_done = done_q;
  assign err_short  = short_q;
  assign err_long   = long_q;
`endif

endmodule

// File: tb/tb_axis_iq_frame_capture.sv
// Scoreboard bench for axis_iq_frame_capture: stimulus queues expected frame results and
// read data; a negedge monitor compares them when frame_done rises or read data returns.
module tb_axis_iq_frame_capture;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] tdata = '0;
  logic [7:0]   tid = '0, tuser = '0, cfg_tid = '0;
  logic         tlast = 1'b0, tvalid = 1'b0, arm = 1'b0;
  logic         tready, busy, frame_done, err_short, err_long;
  logic [8:0]   rd_addr = '0;
  logic [127:0] rd_data;
  logic [9:0]   beat_count;
`ifdef IQ_CAPTURE_ENERGY_EN
  logic [47:0]  frame_energy;
`endif

  int checks = 0;
  int errors = 0;

  string        name_q[$];
  logic [11:0]  exp_q[$];
  logic [127:0] rd_q[$];
  logic         prev_done = 1'b0;

  always #5 clk = ~clk;

  axis_iq_frame_capture dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tid    (tid),
    .s_axis_tlast  (tlast),
    .s_axis_tuser  (tuser),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .arm           (arm),
    .cfg_tid       (cfg_tid),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_short     (err_short),
    .err_long      (err_long),
    .beat_count    (beat_count)
`ifdef IQ_CAPTURE_ENERGY_EN
    ,
    .frame_energy  (frame_energy)
`endif
  );

  // Monitor: pops expected read data and frame results as the DUT presents them.
  always @(negedge clk) begin : monitor
    logic [127:0] e_rd;
    logic [11:0]  e_fr;
    string        n;
    if (rd_q.size() != 0) begin
      e_rd = rd_q.pop_front();
      checks++;
      if (rd_data !== e_rd) begin
        errors++;
        $display("FAIL rd_data act=%0h exp=%0h", rd_data, e_rd);
      end
    end
    if (frame_done && !prev_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_done act=1 exp=0 at %0t", $time);
      end else begin
        n    = name_q.pop_front();
        e_fr = exp_q.pop_front();
        if ({err_short, err_long, beat_count} !== e_fr) begin
          errors++;
          $display("FAIL %s frame short/long/count act=%0d/%0d/%0d exp=%0d/%0d/%0d",
                   n, err_short, err_long, beat_count, e_fr[11], e_fr[10], e_fr[9:0]);
        end
      end
    end
    prev_done = frame_done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [7:0] id, input logic last);
    tdata  = d;
    tid    = id;
    tlast  = last;
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic frame(input int base, input int n, input int last_at, input logic [7:0] id);
    for (int k = 0; k < n; k++) send(128'(base + k), id, k == last_at);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic expect_frame(input string n, input logic s, input logic l, input logic [9:0] c);
    name_q.push_back(n);
    exp_q.push_back({s, l, c});
  endtask

  task automatic rd(input logic [8:0] a, input logic [127:0] e);
    rd_addr = a;
    tick();
    rd_q.push_back(e);
  endtask

  task automatic drain(input string n);
    for (int c = 0; c < 40 && (exp_q.size() != 0 || rd_q.size() != 0); c++) tick();
    chk({n, "_pending"}, 128'(exp_q.size() + rd_q.size()), 128'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(); tick();
    chk("reset_tready", 128'(tready), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_flags", 128'({frame_done, err_short, err_long}), 128'(0));
    chk("reset_count", 128'(beat_count), 128'(0));
    rst = 1'b0;
    tick();
    chk("tready_after_reset", 128'(tready), 128'(1));

    // 1: sync on a lone tlast, then a full frame with data = beat index
    pulse_arm();
    chk("t1_busy_sync", 128'(busy), 128'(1));
    send(128'hffff, 8'd0, 1'b1);
    chk("t1_count_after_sync", 128'(beat_count), 128'(0));
    expect_frame("t1", 1'b0, 1'b0, 10'd320);
    frame(0, 320, 319, 8'd0);
    drain("t1");
    chk("t1_busy_done", 128'(busy), 128'(0));
    rd(9'd5, 128'd5);
    rd(9'd319, 128'd319);

    // 2: short frame, tlast on beat 99
    pulse_arm();
    chk("t2_done_cleared", 128'(frame_done), 128'(0));
    expect_frame("t2", 1'b1, 1'b0, 10'd100);
    frame(1000, 100, 99, 8'd0);
    drain("t2");
    rd(9'd99, 128'd1099);

    // 3: long frame, tlast on beat 329
    pulse_arm();
    frame(2000, 329, 1000, 8'd0);
    chk("t3_err_long", 128'(err_long), 128'(1));
    chk("t3_not_done", 128'(frame_done), 128'(0));
    chk("t3_busy", 128'(busy), 128'(1));
    chk("t3_count_sat", 128'(beat_count), 128'(320));
    expect_frame("t3", 1'b0, 1'b1, 10'd320);
    send(128'(2329), 8'd0, 1'b1);
    drain("t3");
    rd(9'd319, 128'd2319);
    rd(9'd0, 128'd2000);

    // 4: arm in DONE while aligned -> direct capture
    pulse_arm();
    chk("t4_flags_cleared", 128'({frame_done, err_short, err_long}), 128'(0));
    chk("t4_count_cleared", 128'(beat_count), 128'(0));
    expect_frame("t4", 1'b0, 1'b0, 10'd320);
    frame(3000, 320, 319, 8'd0);
    drain("t4");
    rd(9'd200, 128'd3200);

    // 5: foreign-tid beats (one carrying tlast) interleaved
    pulse_arm();
    expect_frame("t5", 1'b0, 1'b0, 10'd320);
    for (int k = 0; k < 320; k++) begin
      send(128'(4000 + k), 8'd0, k == 319);
      if (k % 40 == 7) send(128'hdead, 8'd1, k == 87);
    end
    drain("t5");
    rd(9'd8, 128'd4008);
    rd(9'd10, 128'd4010);

    // 6: reset mid-capture
    pulse_arm();
    frame(5000, 50, 1000, 8'd0);
    chk("t6_count_before_reset", 128'(beat_count), 128'(50));
    rst = 1'b1;
    #1;
    chk("t6_tready", 128'(tready), 128'(0));
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_flags", 128'({frame_done, err_short, err_long}), 128'(0));
    chk("t6_count", 128'(beat_count), 128'(0));
    tick();
    rst = 1'b0;
    tick();
    pulse_arm();
    chk("t6_busy_sync", 128'(busy), 128'(1));
    send(128'd6000, 8'd0, 1'b0);
    chk("t6_sync_drops", 128'(beat_count), 128'(0));
    send(128'd6001, 8'd0, 1'b1);
    send(128'd6002, 8'd0, 1'b0);
    chk("t6_capture_resumed", 128'(beat_count), 128'(1));
    rd(9'd0, 128'd6002);
    rd(9'd49, 128'd5049);

`ifdef IQ_CAPTURE_ENERGY_EN
    pulse_arm();
    send(128'hffff, 8'd0, 1'b1);
    expect_frame("energy", 1'b0, 1'b0, 10'd320);
    for (int k = 0; k < 320; k++) send({4{16'd0, 16'd1000}}, 8'd0, k == 319);
    drain("energy");
    chk("frame_energy", 128'(frame_energy), 128'(1280000000));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
